// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, variable-latency instruction-memory handshake
// and the IF/ID pipeline register, steered by the hazard unit's stall/flush controls.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        PCWrite_i,
    input  logic        IFIDStall_i,
    input  logic        IFIDFlush_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_IFID_o,
    output logic [31:0] inst_IFID_o,
    output logic        valid_IFID_o,
    output logic        fetch_busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DROP  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] pc_r;
    logic [31:0] pc_s;
    logic [31:0] tgt_r;
    logic [31:0] tgt_s;
    logic [31:0] hold_r;
    logic [31:0] hold_s;
    logic [31:0] pc_ifid_r;
    logic [31:0] pc_ifid_s;
    logic [31:0] inst_ifid_r;
    logic [31:0] inst_ifid_s;
    logic        valid_ifid_r;
    logic        valid_ifid_s;
    logic        req_r;
    logic        busy_r;
    logic        stall_s;
    logic [31:0] target_s;

    function automatic logic [31:0] next_word(input logic [31:0] addr);
        next_word = addr + 32'd4;
    endfunction

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        align_word = {addr[31:2], 2'b00};
    endfunction

    assign stall_s  = IFIDStall_i | ~PCWrite_i;
    assign target_s = align_word(branch_target_i);

    // Next-state, next-PC and IF/ID update; flush outranks stall, stall outranks advance.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        tgt_s        = tgt_r;
        hold_s       = hold_r;
        pc_ifid_s    = pc_ifid_r;
        inst_ifid_s  = inst_ifid_r;
        valid_ifid_s = valid_ifid_r;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    state_s = FETCH;
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                if (imem_ready_i) begin
                    if (IFIDFlush_i) begin
                        pc_s         = target_s;
                        inst_ifid_s  = NOP_INST;
                        valid_ifid_s = 1'b0;
                    end else if (stall_s) begin
                        hold_s  = imem_rdata_i;
                        state_s = HOLD;
                    end else begin
                        pc_ifid_s    = pc_r;
                        inst_ifid_s  = imem_rdata_i;
                        valid_ifid_s = 1'b1;
                        pc_s         = next_word(pc_r);
                    end
                end else begin
                    if (IFIDFlush_i) begin
                        tgt_s        = target_s;
                        inst_ifid_s  = NOP_INST;
                        valid_ifid_s = 1'b0;
                        state_s      = DROP;
                    end else if (stall_s) begin
                        state_s = FETCH;
                    end else begin
                        inst_ifid_s  = NOP_INST;
                        valid_ifid_s = 1'b0;
                    end
                end
            end
            DROP: begin
                if (IFIDFlush_i) begin
                    tgt_s        = target_s;
                    inst_ifid_s  = NOP_INST;
                    valid_ifid_s = 1'b0;
                end else if (stall_s) begin
                    tgt_s = tgt_r;
                end else begin
                    inst_ifid_s  = NOP_INST;
                    valid_ifid_s = 1'b0;
                end
                // The stale word is thrown away; a flush in the same cycle supplies the newest target.
                if (imem_ready_i) begin
                    pc_s    = IFIDFlush_i ? target_s : tgt_r;
                    state_s = FETCH;
                end else begin
                    state_s = DROP;
                end
            end
            HOLD: begin
                if (IFIDFlush_i) begin
                    pc_s         = target_s;
                    inst_ifid_s  = NOP_INST;
                    valid_ifid_s = 1'b0;
                    state_s      = FETCH;
                end else if (!stall_s) begin
                    pc_ifid_s    = pc_r;
                    inst_ifid_s  = hold_r;
                    valid_ifid_s = 1'b1;
                    pc_s         = next_word(pc_r);
                    state_s      = FETCH;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, PC and IF/ID registers; request and busy flags are registered from the next state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r      <= IDLE;
            pc_r         <= RESET_PC;
            tgt_r        <= 32'h0000_0000;
            hold_r       <= 32'h0000_0000;
            pc_ifid_r    <= 32'h0000_0000;
            inst_ifid_r  <= NOP_INST;
            valid_ifid_r <= 1'b0;
            req_r        <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            tgt_r        <= tgt_s;
            hold_r       <= hold_s;
            pc_ifid_r    <= pc_ifid_s;
            inst_ifid_r  <= inst_ifid_s;
            valid_ifid_r <= valid_ifid_s;
            req_r        <= (state_s == FETCH) || (state_s == DROP);
            busy_r       <= (state_s == DROP) || (state_s == HOLD);
        end
    end

    assign imem_req_o   = req_r;
    assign imem_addr_o  = pc_r;
    assign pc_IFID_o    = pc_ifid_r;
    assign inst_IFID_o  = inst_ifid_r;
    assign valid_IFID_o = valid_ifid_r;
    assign fetch_busy_o = busy_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized stall/flush/latency traffic,
// checked cycle by cycle against a queue-based behavioural model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, start, pcw, stall, flush, ready;
    logic [31:0] tgt, rdata;
    logic        req, valid, busy;
    logic [31:0] addr, pc_ifid, inst_ifid;
    logic        req2, valid2, busy2;
    logic [31:0] addr2, pc_ifid2, inst_ifid2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .PCWrite_i(pcw),
        .IFIDStall_i(stall), .IFIDFlush_i(flush), .branch_target_i(tgt),
        .imem_req_o(req), .imem_addr_o(addr), .imem_ready_i(ready), .imem_rdata_i(rdata),
        .pc_IFID_o(pc_ifid), .inst_IFID_o(inst_ifid), .valid_IFID_o(valid), .fetch_busy_o(busy)
    );

    // Second instance starting at the top of the address space, zero-wait memory.
    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INST(NOP)) dut_wrap (
        .clk_i(clk), .rst_i(rst), .start_i(start), .PCWrite_i(1'b1),
        .IFIDStall_i(1'b0), .IFIDFlush_i(1'b0), .branch_target_i(32'h0000_0000),
        .imem_req_o(req2), .imem_addr_o(addr2), .imem_ready_i(1'b1), .imem_rdata_i(32'h0000_0000),
        .pc_IFID_o(pc_ifid2), .inst_IFID_o(inst_ifid2), .valid_IFID_o(valid2), .fetch_busy_o(busy2)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: fetch pointer, optional parked word, optional pending redirect.
    bit          m_run, m_drop, m_ifid_valid;
    logic [31:0] m_pc, m_drop_tgt, m_ifid_pc, m_ifid_inst;
    logic [31:0] m_park[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0000_0100 + a;
    endfunction

    function automatic void model_reset();
        m_run = 1'b0; m_drop = 1'b0; m_pc = 32'h0000_0000; m_drop_tgt = 32'h0000_0000;
        m_ifid_pc = 32'h0000_0000; m_ifid_inst = NOP; m_ifid_valid = 1'b0;
        m_park.delete();
    endfunction

    function automatic void model_bubble();
        m_ifid_inst = NOP;
        m_ifid_valid = 1'b0;
    endfunction

    function automatic void model_deliver(input logic [31:0] w);
        m_ifid_pc = m_pc;
        m_ifid_inst = w;
        m_ifid_valid = 1'b1;
        m_pc = m_pc + 32'd4;
    endfunction

    function automatic void model_step();
        bit          st;
        logic [31:0] t;
        st = stall | ~pcw;
        t = tgt & 32'hFFFF_FFFC;
        if (!m_run) begin
            if (start) m_run = 1'b1;
        end else if (m_park.size() != 0) begin
            if (flush) begin
                m_park.delete(); m_pc = t; model_bubble();
            end else if (!st) begin
                model_deliver(m_park.pop_front());
            end
        end else if (m_drop) begin
            if (flush) begin
                m_drop_tgt = t; model_bubble();
            end else if (!st) begin
                model_bubble();
            end
            if (ready) begin
                m_drop = 1'b0; m_pc = m_drop_tgt;
            end
        end else if (ready) begin
            if (flush) begin
                m_pc = t; model_bubble();
            end else if (st) begin
                m_park.push_back(mem_word(m_pc));
            end else begin
                model_deliver(mem_word(m_pc));
            end
        end else begin
            if (flush) begin
                m_drop = 1'b1; m_drop_tgt = t; model_bubble();
            end else if (!st) begin
                model_bubble();
            end
        end
    endfunction

    task automatic compare_all();
        check_val("req", {31'd0, req}, {31'd0, m_run && m_park.size() == 0});
        check_val("addr", addr, m_pc);
        check_val("pc_ifid", pc_ifid, m_ifid_pc);
        check_val("inst_ifid", inst_ifid, m_ifid_inst);
        check_val("valid_ifid", {31'd0, valid}, {31'd0, m_ifid_valid});
        check_val("busy", {31'd0, busy}, {31'd0, m_drop || m_park.size() != 0});
    endtask

    int lat_left, fixed_lat;
    bit rand_lat;

    // One clock: drive inputs and memory response, advance the model, sample on the falling edge.
    task automatic step(input bit s_start, input bit s_pcw, input bit s_stall,
                        input bit s_flush, input logic [31:0] s_tgt);
        start = s_start; pcw = s_pcw; stall = s_stall; flush = s_flush; tgt = s_tgt;
        if (req && lat_left == 0) begin
            ready = 1'b1; rdata = mem_word(addr);
        end else begin
            ready = 1'b0; rdata = 32'hDEAD_BEEF;
        end
        if (req) begin
            if (lat_left == 0) lat_left = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
            else lat_left--;
        end
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pcw = 1'b1; stall = 1'b0; flush = 1'b0;
        tgt = 32'h0; ready = 1'b0; rdata = 32'h0;
        lat_left = 0; fixed_lat = 0; rand_lat = 1'b0;
        model_reset();
        @(negedge clk);
        compare_all();
        check_val("wrap_reset_addr", addr2, 32'hFFFF_FFFC);
        rst = 1'b0;

        // Zero-wait streaming
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check_val("first_edge_valid", {31'd0, valid}, 32'd0);
        check_val("wrap_first_addr", addr2, 32'hFFFF_FFFC);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check_val("second_edge_valid", {31'd0, valid}, 32'd1);
        check_val("first_inst", inst_ifid, 32'h0000_0100);
        check_val("wrap_second_addr", addr2, 32'h0000_0000);
        check_val("wrap_first_pc", pc_ifid2, 32'hFFFF_FFFC);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check_val("stream_pc8", pc_ifid, 32'h0000_0008);

        // Two-cycle stall while IF/ID holds pc 8
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check_val("stall1_pc", pc_ifid, 32'h0000_0008);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check_val("stall2_pc", pc_ifid, 32'h0000_0008);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check_val("after_stall_pc", pc_ifid, 32'h0000_000C);
        check_val("after_stall_inst", inst_ifid, 32'h0000_010C);

        // Flush to 0x40 while fetching 0x10 with ready high
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0040);
        check_val("flush_bubble_inst", inst_ifid, NOP);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check_val("flush_target_pc", pc_ifid, 32'h0000_0040);

        // Three-cycle latency with two flushes during the wait
        lat_left = 2;
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0080);
        check_val("drop_addr1", addr, 32'h0000_0044);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0093);
        check_val("drop_addr2", addr, 32'h0000_0044);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check_val("drop_new_addr", addr, 32'h0000_0090);

        // Flush and stall together while a word is parked
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check_val("hold_busy", {31'd0, busy}, 32'd1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_00A0);
        check_val("hold_flush_addr", addr, 32'h0000_00A0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check_val("hold_flush_pc", pc_ifid, 32'h0000_00A0);

        // Stall through PCWrite low
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check_val("pcwrite_release_pc", pc_ifid, 32'h0000_00A4);

        // Reset in the middle of a memory wait
        lat_left = 3;
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        #2 rst = 1'b1;
        #1;
        check_val("midrst_req", {31'd0, req}, 32'd0);
        check_val("midrst_addr", addr, 32'h0);
        check_val("midrst_valid", {31'd0, valid}, 32'd0);
        check_val("midrst_inst", inst_ifid, NOP);
        check_val("midrst_busy", {31'd0, busy}, 32'd0);
        model_reset();
        ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        lat_left = 0;

        // Randomized traffic
        rand_lat = 1'b1;
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 6) == 0, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
